// File: rtl/ctrl_pipe_unit_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit_pkg
// Shared types for the pipelined control unit: RV32I opcode constants, the
// ALU/immediate selectors, the valid-free control bundle (control_t), the
// per-stage record (stage_t) and small helpers used by decode and interlock.
// No ports; imported with `import ctrl_pipe_unit_pkg::*`.
// ---------------------------------------------------------------------------
package ctrl_pipe_unit_pkg;

  // Widest register index a stage record can hold; narrower indices are
  // zero-extended into it.
  localparam int RD_MAX_W = 8;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_t;

  typedef struct packed {
    alu_op_t    alu_op;
    imm_sel_t   imm_sel;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       rf_write_enable;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] funct3;      // access size / branch condition
  } control_t;

  typedef struct packed {
    logic                valid;
    control_t            ctrl;
    logic [RD_MAX_W-1:0] rd;
  } stage_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode == OPCODE_OP)    || (opcode == OPCODE_OP_IMM) ||
           (opcode == OPCODE_LOAD)  || (opcode == OPCODE_JALR)   ||
           (opcode == OPCODE_STORE) || (opcode == OPCODE_BRANCH);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPCODE_OP) || (opcode == OPCODE_STORE) ||
           (opcode == OPCODE_BRANCH);
  endfunction

  // alt selects SUB/SRA; callers only set it where funct7[5] is meaningful.
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // A valid load in stage s writes a register that the ID instruction reads.
  function automatic logic hits_load(input stage_t s,
                                     input logic [RD_MAX_W-1:0] rs1,
                                     input logic [RD_MAX_W-1:0] rs2,
                                     input logic u1, input logic u2);
    return s.valid && s.ctrl.mem_read && (s.rd != '0) &&
           ((u1 && (s.rd == rs1)) || (u2 && (s.rd == rs2)));
  endfunction

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit_if
// Bundles the ID-stage instruction fields, the EX redirect, the hazard
// outputs and the EX/MEM/WB control taps of ctrl_pipe_unit.
//   master : pipeline/datapath side (drives id_*, ex_redirect)
//   slave  : ctrl_pipe_unit
// With CTRL_PERF_CNT_EN defined the stall/flush/illegal counters are added.
// ---------------------------------------------------------------------------
interface ctrl_pipe_unit_if #(parameter int REG_ADDR_W = 5);
  import ctrl_pipe_unit_pkg::*;

  logic                  id_valid;
  logic [6:0]            id_opcode;
  logic [2:0]            id_funct3;
  logic [6:0]            id_funct7;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_redirect;

  logic                  stall;
  logic                  flush;
  logic                  illegal_instr;
  logic                  ex_valid;
  control_t              ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid;
  control_t              mem_ctrl;
  logic                  wb_valid;
  control_t              wb_ctrl;
  logic [REG_ADDR_W-1:0] wb_rd;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0]           stall_cnt;
  logic [31:0]           flush_cnt;
  logic [31:0]           illegal_cnt;
`endif

  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
           ex_redirect,
    input  stall, flush, illegal_instr, ex_valid, ex_ctrl, ex_rd,
           mem_valid, mem_ctrl, wb_valid, wb_ctrl, wb_rd
`ifdef CTRL_PERF_CNT_EN
    , input stall_cnt, flush_cnt, illegal_cnt
`endif
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
           ex_redirect,
    output stall, flush, illegal_instr, ex_valid, ex_ctrl, ex_rd,
           mem_valid, mem_ctrl, wb_valid, wb_ctrl, wb_rd
`ifdef CTRL_PERF_CNT_EN
    , output stall_cnt, flush_cnt, illegal_cnt
`endif
  );

endinterface

// File: rtl/ctrl_pipe_unit_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Combinational RV32I control decoder.
//   opcode/funct3/funct7 in -> ctrl (control_t), illegal
// Unknown opcodes, and unknown funct3/funct7 combinations of known opcodes,
// raise illegal and return an all-zero bundle so they behave as bubbles.
// ---------------------------------------------------------------------------
module ctrl_decode
  import ctrl_pipe_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output control_t   ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        ctrl.rf_write_enable = 1'b1;
        ctrl.alu_op          = alu_from_f3(funct3, funct7[5]);
        if (funct7 == 7'h20)
          illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
        else
          illegal = (funct7 != 7'h00);
      end
      OPCODE_OP_IMM: begin
        ctrl.rf_write_enable = 1'b1;
        ctrl.alu_src_imm     = 1'b1;
        ctrl.imm_sel         = IMM_I;
        // funct7 only carries meaning for the shift-immediates
        ctrl.alu_op          = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPCODE_LOAD: begin
        ctrl.rf_write_enable = 1'b1;
        ctrl.alu_src_imm     = 1'b1;
        ctrl.imm_sel         = IMM_I;
        ctrl.mem_read        = 1'b1;
        ctrl.mem_to_reg      = 1'b1;
        ctrl.funct3          = funct3;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPCODE_JALR: begin
        ctrl.rf_write_enable = 1'b1;
        ctrl.alu_src_imm     = 1'b1;
        ctrl.imm_sel         = IMM_I;
        ctrl.jump            = 1'b1;
        ctrl.jalr            = 1'b1;
        illegal = (funct3 != 3'b000);
      end
      OPCODE_STORE: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.imm_sel     = IMM_S;
        ctrl.mem_write   = 1'b1;
        ctrl.funct3      = funct3;
        illegal = (funct3 > 3'b010);
      end
      OPCODE_BRANCH: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.imm_sel = IMM_B;
        ctrl.branch  = 1'b1;
        ctrl.funct3  = funct3;
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPCODE_LUI: begin
        ctrl.rf_write_enable = 1'b1;
        ctrl.alu_src_imm     = 1'b1;
        ctrl.imm_sel         = IMM_U;
        ctrl.alu_op          = ALU_PASS_B;
      end
      OPCODE_AUIPC: begin
        ctrl.rf_write_enable = 1'b1;
        ctrl.alu_src_imm     = 1'b1;
        ctrl.alu_src_pc      = 1'b1;
        ctrl.imm_sel         = IMM_U;
      end
      OPCODE_JAL: begin
        ctrl.rf_write_enable = 1'b1;
        ctrl.alu_src_imm     = 1'b1;
        ctrl.alu_src_pc      = 1'b1;
        ctrl.imm_sel         = IMM_J;
        ctrl.jump            = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) ctrl = '0;
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_unit
// Pipelined control: decodes the ID instruction, carries {valid, ctrl, rd}
// through EX, LOAD_LATENCY MEM registers and WB, and generates the load-use
// stall and the branch/jump flush for the IF/ID registers.
// Ports:
//   clk    pipeline clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    ctrl_pipe_unit_if.slave (ID fields, ex_redirect, stall/flush,
//          illegal_instr, EX/MEM/WB taps)
// Parameters: LOAD_LATENCY (1..2), REG_ADDR_W, ZERO_RD_SUPPRESS.
// Optional macro CTRL_PERF_CNT_EN adds saturating stall/flush/illegal
// cycle counters on the interface.
// ---------------------------------------------------------------------------
module ctrl_pipe_unit
  import ctrl_pipe_unit_pkg::*;
#(
  parameter int LOAD_LATENCY     = 1,
  parameter int REG_ADDR_W       = 5,
  parameter int ZERO_RD_SUPPRESS = 1
) (
  input logic             clk,
  input logic             rst_n,
  ctrl_pipe_unit_if.slave bus
);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 2) begin : g_bad_latency
    $error("ctrl_pipe_unit: LOAD_LATENCY must be 1 or 2");
  end
  if (REG_ADDR_W > RD_MAX_W) begin : g_bad_addr_w
    $error("ctrl_pipe_unit: REG_ADDR_W exceeds RD_MAX_W");
  end

  control_t            dec_ctrl;
  control_t            id_ctrl;
  logic                dec_illegal;
  logic [RD_MAX_W-1:0] rs1_ext, rs2_ext, rd_ext;
  logic                load_use;
  logic                stall_w, flush_w, illegal_w;

  stage_t ex_q, ex_d;
  stage_t wb_q, wb_d;
  stage_t mem_q [LOAD_LATENCY];
  stage_t mem_d [LOAD_LATENCY];

  ctrl_decode u_decode (
    .opcode  (bus.id_opcode),
    .funct3  (bus.id_funct3),
    .funct7  (bus.id_funct7),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign rs1_ext = RD_MAX_W'(bus.id_rs1);
  assign rs2_ext = RD_MAX_W'(bus.id_rs2);
  assign rd_ext  = RD_MAX_W'(bus.id_rd);

  // A load is still unresolved in EX and in every MEM register except the
  // last one, which hands its data to the forwarding path in time.
  always_comb begin
    load_use = 1'b0;
    if (bus.id_valid) begin
      if (hits_load(ex_q, rs1_ext, rs2_ext, uses_rs1(bus.id_opcode), uses_rs2(bus.id_opcode)))
        load_use = 1'b1;
      for (int k = 0; k < LOAD_LATENCY - 1; k++) begin
        if (hits_load(mem_q[k], rs1_ext, rs2_ext, uses_rs1(bus.id_opcode), uses_rs2(bus.id_opcode)))
          load_use = 1'b1;
      end
    end
  end

  // The redirect squashes the instruction being stalled, so flush wins.
  assign flush_w   = bus.ex_redirect;
  assign stall_w   = load_use & ~bus.ex_redirect;
  assign illegal_w = bus.id_valid & dec_illegal;

  always_comb begin
    id_ctrl = dec_ctrl;
    if ((ZERO_RD_SUPPRESS != 0) && (bus.id_rd == '0))
      id_ctrl.rf_write_enable = 1'b0;

    ex_d = '0;
    if (bus.id_valid && !dec_illegal && !load_use && !bus.ex_redirect) begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = id_ctrl;
      ex_d.rd    = rd_ext;
    end

    mem_d[0] = ex_q;
    for (int k = 1; k < LOAD_LATENCY; k++) mem_d[k] = mem_q[k-1];
    wb_d = mem_q[LOAD_LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      wb_q <= '0;
      for (int k = 0; k < LOAD_LATENCY; k++) mem_q[k] <= '0;
    end else begin
      ex_q <= ex_d;
      wb_q <= wb_d;
      for (int k = 0; k < LOAD_LATENCY; k++) mem_q[k] <= mem_d[k];
    end
  end

  assign bus.stall         = stall_w;
  assign bus.flush         = flush_w;
  assign bus.illegal_instr = illegal_w;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_ctrl       = ex_q.ctrl;
  assign bus.ex_rd         = ex_q.rd[REG_ADDR_W-1:0];
  assign bus.mem_valid     = mem_q[LOAD_LATENCY-1].valid;
  assign bus.mem_ctrl      = mem_q[LOAD_LATENCY-1].ctrl;
  assign bus.wb_valid      = wb_q.valid;
  assign bus.wb_ctrl       = wb_q.ctrl;
  assign bus.wb_rd         = wb_q.rd[REG_ADDR_W-1:0];

`ifdef CTRL_PERF_CNT_EN
  logic [2:0]  evt;
  logic [31:0] cnt_q [3];
  logic [31:0] cnt_d [3];

  assign evt = {illegal_w, flush_w, stall_w};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (evt[i] && (cnt_q[i] != 32'hFFFF_FFFF)) cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.stall_cnt   = cnt_q[0];
  assign bus.flush_cnt   = cnt_q[1];
  assign bus.illegal_cnt = cnt_q[2];
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe_unit
// Directed scenarios plus a randomized instruction stream for ctrl_pipe_unit.
// A reference model (instruction-class decode table + list of in-flight
// instructions) predicts every output each cycle. Honours CTRL_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe_unit;
  import ctrl_pipe_unit_pkg::*;

  localparam int TB_LL = 2;
  localparam int NST   = TB_LL + 2;   // EX, MEM[0..LL-1], WB

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe_unit_if #(.REG_ADDR_W(5)) bus ();

  ctrl_pipe_unit #(
    .LOAD_LATENCY(TB_LL), .REG_ADDR_W(5), .ZERO_RD_SUPPRESS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // model: in-flight instruction list, index 0 = EX ... NST-1 = WB
  bit          m_valid [NST];
  control_t    m_ctrl  [NST];
  logic [4:0]  m_rd    [NST];
  logic [31:0] m_cnt   [3];
  bit e_stall, e_flush, e_illegal;
  bit obs_stall, obs_flush, obs_illegal;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference decode: instruction class from opcode, legality from the list
  // of RV32I encodings, then the control fields that class needs.
  task automatic ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            output control_t c, output bit legal);
    alu_op_t by_f3 [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    c = '0;
    legal = 1;
    if (op == 7'b0110011) begin
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      c.alu_op = by_f3[f3];
      if (f7 == 7'h20 && f3 == 0) c.alu_op = ALU_SUB;
      if (f7 == 7'h20 && f3 == 5) c.alu_op = ALU_SRA;
      c.rf_write_enable = 1;
    end else if (op == 7'b0010011) begin
      legal = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20);
      c.alu_op = by_f3[f3];
      if (f3 == 5 && f7[5]) c.alu_op = ALU_SRA;
      c.rf_write_enable = 1; c.alu_src_imm = 1; c.imm_sel = IMM_I;
    end else if (op == 7'b0000011) begin
      legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      c.rf_write_enable = 1; c.alu_src_imm = 1; c.imm_sel = IMM_I;
      c.mem_read = 1; c.mem_to_reg = 1; c.funct3 = f3;
    end else if (op == 7'b1100111) begin
      legal = (f3 == 0);
      c.rf_write_enable = 1; c.alu_src_imm = 1; c.imm_sel = IMM_I; c.jump = 1; c.jalr = 1;
    end else if (op == 7'b0100011) begin
      legal = (f3 inside {3'd0, 3'd1, 3'd2});
      c.alu_src_imm = 1; c.imm_sel = IMM_S; c.mem_write = 1; c.funct3 = f3;
    end else if (op == 7'b1100011) begin
      legal = !(f3 inside {3'd2, 3'd3});
      c.alu_op = ALU_SUB; c.imm_sel = IMM_B; c.branch = 1; c.funct3 = f3;
    end else if (op == 7'b0110111) begin
      c.rf_write_enable = 1; c.alu_src_imm = 1; c.imm_sel = IMM_U; c.alu_op = ALU_PASS_B;
    end else if (op == 7'b0010111) begin
      c.rf_write_enable = 1; c.alu_src_imm = 1; c.alu_src_pc = 1; c.imm_sel = IMM_U;
    end else if (op == 7'b1101111) begin
      c.rf_write_enable = 1; c.alu_src_imm = 1; c.alu_src_pc = 1; c.imm_sel = IMM_J; c.jump = 1;
    end else begin
      legal = 0;
    end
    if (!legal) c = '0;
  endtask

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NST; i++) begin
      m_valid[i] = 0; m_ctrl[i] = '0; m_rd[i] = '0;
    end
    for (int i = 0; i < 3; i++) m_cnt[i] = '0;
  endtask

  // One clock cycle: compare at the falling edge, advance model at rising edge.
  task automatic step();
    control_t dc;
    bit legal, haz;
    @(negedge clk);
    ref_decode(bus.id_opcode, bus.id_funct3, bus.id_funct7, dc, legal);
    haz = 0;
    if (bus.id_valid) begin
      for (int i = 0; i < TB_LL; i++) begin
        if (m_valid[i] && m_ctrl[i].mem_read && m_rd[i] != 0 &&
            ((reads_rs1(bus.id_opcode) && m_rd[i] == bus.id_rs1) ||
             (reads_rs2(bus.id_opcode) && m_rd[i] == bus.id_rs2)))
          haz = 1;
      end
    end
    e_flush   = bus.ex_redirect;
    e_stall   = haz && !e_flush;
    e_illegal = bus.id_valid && !legal;
    obs_stall = bus.stall; obs_flush = bus.flush; obs_illegal = bus.illegal_instr;
    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("flush", 64'(bus.flush), 64'(e_flush));
    chk("illegal_instr", 64'(bus.illegal_instr), 64'(e_illegal));
    chk("ex_valid", 64'(bus.ex_valid), 64'(m_valid[0]));
    chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl[0]));
    chk("ex_rd", 64'(bus.ex_rd), 64'(m_rd[0]));
    chk("mem_valid", 64'(bus.mem_valid), 64'(m_valid[TB_LL]));
    chk("mem_ctrl", 64'(bus.mem_ctrl), 64'(m_ctrl[TB_LL]));
    chk("wb_valid", 64'(bus.wb_valid), 64'(m_valid[NST-1]));
    chk("wb_ctrl", 64'(bus.wb_ctrl), 64'(m_ctrl[NST-1]));
    chk("wb_rd", 64'(bus.wb_rd), 64'(m_rd[NST-1]));
`ifdef CTRL_PERF_CNT_EN
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt[0]));
    chk("flush_cnt", 64'(bus.flush_cnt), 64'(m_cnt[1]));
    chk("illegal_cnt", 64'(bus.illegal_cnt), 64'(m_cnt[2]));
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int i = NST - 1; i > 0; i--) begin
        m_valid[i] = m_valid[i-1]; m_ctrl[i] = m_ctrl[i-1]; m_rd[i] = m_rd[i-1];
      end
      if (bus.id_valid && legal && !e_stall && !e_flush) begin
        m_valid[0] = 1; m_ctrl[0] = dc; m_rd[0] = bus.id_rd;
        if (bus.id_rd == 0) m_ctrl[0].rf_write_enable = 0;
      end else begin
        m_valid[0] = 0; m_ctrl[0] = '0; m_rd[0] = '0;
      end
      if (e_stall   && m_cnt[0] != 32'hFFFF_FFFF) m_cnt[0]++;
      if (e_flush   && m_cnt[1] != 32'hFFFF_FFFF) m_cnt[1]++;
      if (e_illegal && m_cnt[2] != 32'hFFFF_FFFF) m_cnt[2]++;
    end
    #1;
  endtask

  task automatic drv(input bit v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input int rs1, input int rs2, input int rd, input bit redir);
    bus.id_valid = v; bus.id_opcode = op; bus.id_funct3 = f3; bus.id_funct7 = f7;
    bus.id_rs1 = 5'(rs1); bus.id_rs2 = 5'(rs2); bus.id_rd = 5'(rd); bus.ex_redirect = redir;
  endtask

  task automatic idle(); drv(0, 7'h0, 3'h0, 7'h0, 0, 0, 0, 0); endtask

  task automatic rand_instr();
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b1100111,
                             7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    int sel = $urandom_range(0, 11);
    logic [6:0] op = (sel < 10) ? ops[sel] : 7'($urandom);
    logic [6:0] f7 = ($urandom_range(0, 9) < 7) ? (($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00)
                                                 : 7'($urandom);
    drv($urandom_range(0, 9) < 8, op, 3'($urandom), f7,
        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
        $urandom_range(0, 7) == 0);
  endtask

  int cnt;

  initial begin
    model_clear();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state pinned to literals
    chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_ctrl", 64'(bus.wb_ctrl), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);

`ifdef CTRL_PERF_CNT_EN
    // 4 stall cycles from load-use pairs, then 2 flush pulses
    for (int p = 0; p < 4 / TB_LL; p++) begin
      drv(1, 7'b0000011, 3'd2, 7'h0, 1, 0, 5, 0); step();
      drv(1, 7'b0110011, 3'd0, 7'h0, 5, 1, 6, 0);
      for (int g = 0; g < 8; g++) begin step(); if (!obs_stall) break; end
      idle(); repeat (TB_LL + 2) step();
    end
    drv(0, 7'h0, 3'h0, 7'h0, 0, 0, 0, 1); step();
    idle(); step();
    drv(0, 7'h0, 3'h0, 7'h0, 0, 0, 0, 1); step();
    idle(); step();
    chk("perf_stall_cnt", 64'(bus.stall_cnt), 64'd4);
    chk("perf_flush_cnt", 64'(bus.flush_cnt), 64'd2);
`endif

    // ADD x3,x1,x2 reaches WB exactly LL+2 edges after ID
    drv(1, 7'b0110011, 3'd0, 7'h00, 1, 2, 3, 0); step();
    idle(); repeat (TB_LL) step();
    chk("add_wb_early", 64'(bus.wb_valid), 64'd0);
    step();
    chk("add_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("add_wb_rd", 64'(bus.wb_rd), 64'd3);
    chk("add_wb_we", 64'(bus.wb_ctrl.rf_write_enable), 64'd1);
    repeat (2) step();

    // LW x5 then ADD x6,x5,x1: LL stall cycles, ADD enters EX once
    drv(1, 7'b0000011, 3'd2, 7'h0, 1, 0, 5, 0); step();
    drv(1, 7'b0110011, 3'd0, 7'h0, 5, 1, 6, 0);
    cnt = 0;
    for (int g = 0; g < 8; g++) begin
      step();
      if (!obs_stall) break;
      cnt++;
      chk("stall_ex_bubble", 64'(bus.ex_valid), 64'd0);
    end
    chk("load_use_stall_cycles", 64'(cnt), 64'(TB_LL));
    chk("add_in_ex_after_stall", 64'(bus.ex_valid && bus.ex_rd == 5'd6), 64'd1);
    idle(); repeat (TB_LL + 2) step();

    // same pair with redirect in the stall cycle: flush wins, ADD dropped
    drv(1, 7'b0000011, 3'd2, 7'h0, 1, 0, 5, 0); step();
    drv(1, 7'b0110011, 3'd0, 7'h0, 5, 1, 6, 1); step();
    chk("redir_stall", 64'(obs_stall), 64'd0);
    chk("redir_flush", 64'(obs_flush), 64'd1);
    chk("redir_ex_bubble", 64'(bus.ex_valid), 64'd0);
    idle();
    cnt = 0;
    for (int g = 0; g < TB_LL + 3; g++) begin
      step();
      if (bus.ex_valid && bus.ex_rd == 5'd6) cnt++;
    end
    chk("no_dup_add", 64'(cnt), 64'd0);

    // opcode 7F is illegal and becomes a bubble
    drv(1, 7'h7F, 3'd0, 7'h0, 1, 2, 4, 0); step();
    chk("illegal_7f", 64'(obs_illegal), 64'd1);
    chk("illegal_ex_bubble", 64'(bus.ex_valid), 64'd0);

    // ADDI x0,x0,1 never writes x0
    drv(1, 7'b0010011, 3'd0, 7'h0, 0, 1, 0, 0); step();
    idle(); repeat (TB_LL + 1) step();
    chk("addi_x0_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("addi_x0_wb_we", 64'(bus.wb_ctrl.rf_write_enable), 64'd0);
    repeat (2) step();

    // randomized stream; ID holds its instruction while stalled
    idle();
    for (int n = 0; n < 3000; n++) begin
      if (e_stall) bus.ex_redirect = ($urandom_range(0, 7) == 0);
      else rand_instr();
      step();
    end

    // mid-stream reset: three ADDs in flight, reset between edges
    drv(1, 7'b0110011, 3'd0, 7'h0, 0, 0, 1, 0); step();
    drv(1, 7'b0110011, 3'd0, 7'h0, 0, 0, 2, 0); step();
    drv(1, 7'b0110011, 3'd0, 7'h0, 0, 0, 3, 0); step();
    chk("pre_rst_ex_valid", 64'(bus.ex_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("async_rst_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    chk("async_rst_ex_rd", 64'(bus.ex_rd), 64'd0);
    chk("async_rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("async_rst_mem_ctrl", 64'(bus.mem_ctrl), 64'd0);
    chk("async_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("async_rst_wb_ctrl", 64'(bus.wb_ctrl), 64'd0);
    model_clear();
    idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
